sprite_line_renderer: RTL

- Per-scanline sprite rasteriser, upstream consumer of the sprite bitmap store's 16-bit read port (port 1).
- On each line start it walks the sprite attribute table, selects sprites covering the line, fetches each one's 16-bit bitmap row and paints coloured pixels into the external line buffer.
- Painter's order: a higher sprite index overwrites a lower one.

---
 rtl/sprite_pkg.sv | 42 ++++
 rtl/sprite_row_shifter.sv | 44 ++++
 rtl/sprite_line_renderer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the scanline sprite renderer.
package sprite_pkg;

  localparam int unsigned SPRITE_H = 16;
  localparam int unsigned SPRITE_W = 16;

  typedef struct packed {
    logic       enable;
    logic [7:0] colour;
    logic [9:0] y;
    logic [9:0] x;
  } sprite_attr_t;

  typedef enum logic [2:0] {
    IDLE,
    ATTR_REQ,
    ATTR_WAIT,
    CHECK,
    FETCH_REQ,
    FETCH_WAIT,
    DRAW,
    FINISH
  } render_state_t;

  // Attribute word layout: [9:0] x, [19:10] y, [27:20] colour, [31] enable.
  function automatic sprite_attr_t unpack_attr(input logic enable,
                                               input logic [27:0] fields);
    sprite_attr_t a;
    a.enable = enable;
    a.colour = fields[27:20];
    a.y      = fields[19:10];
    a.x      = fields[9:0];
    return a;
  endfunction

  // Signed 11-bit distance of the scanline below the sprite's top row.
  function automatic logic [10:0] sprite_row(input logic [9:0] line,
                                             input logic [9:0] y);
    return {1'b0, line} - {1'b0, y};
  endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// Holds one fetched bitmap row and walks it leftmost pixel first.
module sprite_row_shifter
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] row,
  input  logic        step,
  output logic        pix,
  output logic [3:0]  px,
  output logic        last
);

  logic [15:0] shift_q, shift_d;
  logic [3:0]  px_q, px_d;

  always_comb begin
    shift_d = shift_q;
    px_d    = px_q;
    if (load) begin
      shift_d = row;
      px_d    = '0;
    end else if (step) begin
      shift_d = {shift_q[14:0], 1'b0};
      px_d    = px_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      px_q    <= '0;
    end else begin
      shift_q <= shift_d;
      px_q    <= px_d;
    end
  end

  assign pix  = shift_q[15];
  assign px   = px_q;
  assign last = (px_q == 4'(SPRITE_W - 1));

endmodule

// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite rasteriser: scans the attribute table, fetches rows of
// sprites covering the line and paints them into the line buffer.
module sprite_line_renderer
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_SPRITES  = 128,
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned MAX_PER_LINE = 16
) (
  input  logic        CLK_100,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  line_num,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [6:0]  attr_addr,
  output logic        attr_rd,
  input  logic [31:0] attr_data,
  output logic [6:0]  addr1_sprite_index,
  output logic [3:0]  addr1_sprite_line,
  output logic        r1,
  input  logic [15:0] data_r1,
  output logic        lb_we,
  output logic [9:0]  lb_addr,
  output logic [7:0]  lb_data
);

  localparam logic [6:0]  LAST_INDEX = 7'(NUM_SPRITES - 1);
  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
  localparam logic [7:0]  MAX_CNT    = 8'(MAX_PER_LINE);

  render_state_t state_q, state_d;
  logic [9:0]    line_q, line_d;
  logic [6:0]    index_q, index_d;
  logic [7:0]    draw_cnt_q, draw_cnt_d;
  logic          ovf_q, ovf_d;
  sprite_attr_t  attr_q, attr_d;

  logic          shift_load, shift_step;
  logic          pix, px_last;
  logic [3:0]    px;
  logic [10:0]   row;
  logic [10:0]   sum;
  logic          visible;
  logic          advance;
  logic          unused_attr_bits;

  assign unused_attr_bits = ^attr_data[30:28];

  sprite_row_shifter u_shifter (
    .clk   (CLK_100),
    .rst_n (reset_n),
    .load  (shift_load),
    .row   (data_r1),
    .step  (shift_step),
    .pix   (pix),
    .px    (px),
    .last  (px_last)
  );

  // No vertical wrap: a negative distance (sign bit) rejects the sprite.
  assign row     = sprite_row(line_q, attr_q.y);
  assign visible = attr_q.enable && !row[10] && (row < 11'(SPRITE_H));
  // 11-bit sum so sprites hanging off the right edge are clipped, not wrapped.
  assign sum     = {1'b0, attr_q.x} + {7'b0, px};

  always_comb begin
    state_d            = state_q;
    line_d             = line_q;
    index_d            = index_q;
    draw_cnt_d         = draw_cnt_q;
    ovf_d              = ovf_q;
    attr_d             = attr_q;
    shift_load         = 1'b0;
    shift_step         = 1'b0;
    advance            = 1'b0;
    attr_rd            = 1'b0;
    attr_addr          = '0;
    r1                 = 1'b0;
    addr1_sprite_index = '0;
    addr1_sprite_line  = '0;
    lb_we              = 1'b0;
    lb_addr            = '0;
    lb_data            = '0;

    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          line_d     = line_num;
          index_d    = '0;
          draw_cnt_d = '0;
          ovf_d      = 1'b0;
          state_d    = ATTR_REQ;
        end
      end
      ATTR_REQ: begin
        attr_rd   = 1'b1;
        attr_addr = index_q;
        state_d   = ATTR_WAIT;
      end
      ATTR_WAIT: begin
        attr_d  = unpack_attr(attr_data[31], attr_data[27:0]);
        state_d = CHECK;
      end
      CHECK: begin
        if (visible) begin
          if (draw_cnt_q == MAX_CNT) begin
            ovf_d   = 1'b1;
            state_d = FINISH;
          end else begin
            state_d = FETCH_REQ;
          end
        end else begin
          advance = 1'b1;
        end
      end
      FETCH_REQ: begin
        r1                 = 1'b1;
        addr1_sprite_index = index_q;
        addr1_sprite_line  = row[3:0];
        state_d            = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        shift_load = 1'b1;
        state_d    = DRAW;
      end
      DRAW: begin
        shift_step = 1'b1;
        lb_we      = pix && (sum < SCREEN_W_L);
        lb_addr    = sum[9:0];
        lb_data    = attr_q.colour;
        if (px_last) begin
          draw_cnt_d = draw_cnt_q + 8'd1;
          advance    = 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (index_q == LAST_INDEX) begin
        state_d = FINISH;
      end else begin
        index_d = index_q + 7'd1;
        state_d = ATTR_REQ;
      end
    end
  end

  always_ff @(posedge CLK_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      line_q     <= '0;
      index_q    <= '0;
      draw_cnt_q <= '0;
      ovf_q      <= 1'b0;
      attr_q     <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      index_q    <= index_d;
      draw_cnt_q <= draw_cnt_d;
      ovf_q      <= ovf_d;
      attr_q     <= attr_d;
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != FINISH);
  assign done     = (state_q == FINISH);
  assign overflow = ovf_q;

endmodule
